// File: rtl/cart_slot_loader_if.sv
// cart_slot_loader_if: HPS ioctl download stream plus the SDRAM byte-write port.
//   ioctl_download/index/wr/addr/dout : HPS -> loader byte stream
//   ioctl_wait                        : loader -> HPS stall
//   sdram_addr/din/we                 : loader -> SDRAM write request
//   sdram_ready                       : SDRAM -> loader write completion pulse
`timescale 1ns/1ps
interface cart_slot_loader_if #(
    parameter int ADDR_W = 25
);
    logic              ioctl_download;
    logic [7:0]        ioctl_index;
    logic              ioctl_wr;
    logic [26:0]       ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic              ioctl_wait;
    logic [ADDR_W-1:0] sdram_addr;
    logic [7:0]        sdram_din;
    logic              sdram_we;
    logic              sdram_ready;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, sdram_ready,
        input  ioctl_wait, sdram_addr, sdram_din, sdram_we
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, sdram_ready,
        output ioctl_wait, sdram_addr, sdram_din, sdram_we
    );
endinterface

// File: rtl/cart_slot_loader.sv
// cart_slot_loader: routes per-slot cartridge images from the HPS ioctl stream into SDRAM windows.
//   clk, reset_n   : clock, synchronous active-low reset
//   bus (slave)    : ioctl byte stream in, ioctl_wait out, SDRAM write port out, sdram_ready in
//   detach         : level, unloads every slot while high
//   mapper_sel     : per-slot mapper selection, any change restarts the core reset
//   rom_enabled    : per-slot valid-image flags
//   rom_size       : per-slot loaded byte count (SPAN_LOG2+1 bits each)
//   load_err       : sticky out-of-window or busy-write error, cleared on download start
//   core_reset     : stretched reset to the MSX core
`timescale 1ns/1ps
module cart_slot_loader #(
    parameter int SLOTS      = 2,
    parameter int INDEX_BASE = 2,
    parameter int SPAN_LOG2  = 20,
    parameter int ADDR_W     = 25,
    parameter int BASE_ADDR  = 0,
    parameter int MAPPER_W   = 4,
    parameter int RST_HOLD   = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    cart_slot_loader_if.slave             bus,
    input  logic                          detach,
    input  logic [SLOTS*MAPPER_W-1:0]     mapper_sel,
    output logic [SLOTS-1:0]              rom_enabled,
    output logic [SLOTS*(SPAN_LOG2+1)-1:0] rom_size,
    output logic                          load_err,
    output logic                          core_reset
);
    localparam int SW = SPAN_LOG2 + 1;
    localparam int CW = SLOTS > 1 ? $clog2(SLOTS) : 1;
    localparam int HW = $clog2(RST_HOLD + 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WAIT} state_t;

    state_t                    state;
    logic                      act_q, pend;
    logic [CW-1:0]             cur, wslot;
    logic [SPAN_LOG2-1:0]      off;
    logic [HW-1:0]             hold;
    logic [SLOTS*MAPPER_W-1:0] snap;
    logic [5:0]                idx;
    logic                      in_rng, active, rise, fall, oow, accept, end_now;
    logic [CW-1:0]             idx_slot;

    assign idx      = bus.ioctl_index[5:0];
    assign in_rng   = ({2'b0, idx} >= 8'(INDEX_BASE)) && ({2'b0, idx} < 8'(INDEX_BASE + SLOTS));
    assign active   = bus.ioctl_download && in_rng;
    assign idx_slot = CW'(idx - 6'(INDEX_BASE));
    assign rise     = active && !act_q;
    assign fall     = !active && act_q;
    assign oow      = |bus.ioctl_addr[26:SPAN_LOG2];
    assign accept   = bus.ioctl_wr && active && state == S_IDLE && !oow;
    // a download end waits until the FSM is idle so the last byte is counted
    assign end_now  = (fall || pend) && state == S_IDLE;

    // the accepting cycle already stalls the HPS, before the FSM leaves IDLE
    assign bus.ioctl_wait = (state != S_IDLE) || (reset_n && accept);
    assign bus.sdram_we   = state == S_WRITE;
    assign core_reset     = hold != '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            act_q          <= 1'b0;
            pend           <= 1'b0;
            cur            <= '0;
            wslot          <= '0;
            off            <= '0;
            hold           <= '0;
            snap           <= mapper_sel;
            bus.sdram_addr <= '0;
            bus.sdram_din  <= '0;
            rom_enabled    <= '0;
            rom_size       <= '0;
            load_err       <= 1'b0;
        end else begin
            act_q <= active;
            snap  <= mapper_sel;
            if (active || detach || mapper_sel != snap)
                hold <= HW'(RST_HOLD);
            else if (hold != '0)
                hold <= hold - 1'b1;
            case (state)
                S_IDLE: if (accept) begin
                    state          <= S_WRITE;
                    wslot          <= idx_slot;
                    off            <= bus.ioctl_addr[SPAN_LOG2-1:0];
                    bus.sdram_addr <= ADDR_W'(BASE_ADDR) + (ADDR_W'(idx_slot) << SPAN_LOG2)
                                      + ADDR_W'(bus.ioctl_addr[SPAN_LOG2-1:0]);
                    bus.sdram_din  <= bus.ioctl_dout;
                end
                S_WRITE: state <= S_WAIT;
                S_WAIT: if (bus.sdram_ready) begin
                    state <= S_IDLE;
                    // off < 2^SPAN_LOG2, so off+1 saturates at the window size naturally
                    if (rom_size[wslot*SW +: SW] <= SW'(off))
                        rom_size[wslot*SW +: SW] <= SW'(off) + SW'(1);
                end
                default: state <= S_IDLE;
            endcase
            if (rise) begin
                cur                         <= idx_slot;
                rom_enabled[idx_slot]       <= 1'b0;
                rom_size[idx_slot*SW +: SW] <= '0;
                load_err                    <= 1'b0;
            end
            if (bus.ioctl_wr && active && (state != S_IDLE || oow))
                load_err <= 1'b1;
            if (fall)
                pend <= 1'b1;
            if (end_now) begin
                rom_enabled[cur] <= |rom_size[cur*SW +: SW];
                pend             <= 1'b0;
            end
            // detach overrides any same-cycle download end or size update
            if (detach) begin
                rom_enabled <= '0;
                rom_size    <= '0;
                pend        <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cart_slot_loader.sv
// tb_cart_slot_loader: directed plus randomized bench for cart_slot_loader against a slot-level model.
`timescale 1ns/1ps
module tb_cart_slot_loader;
    localparam int SLOTS = 4;
    localparam int IB    = 2;
    localparam int SPAN  = 20;
    localparam int BASE  = 32'h100000;
    localparam int SW    = SPAN + 1;

    logic                   clk;
    logic                   reset_n;
    logic                   detach;
    logic [SLOTS*4-1:0]     mapper_sel;
    logic [SLOTS-1:0]       rom_enabled;
    logic [SLOTS*SW-1:0]    rom_size;
    logic                   load_err;
    logic                   core_reset;

    cart_slot_loader_if #(.ADDR_W(25)) bus ();

    cart_slot_loader #(
        .SLOTS(SLOTS), .INDEX_BASE(IB), .SPAN_LOG2(SPAN), .ADDR_W(25),
        .BASE_ADDR(BASE), .MAPPER_W(4), .RST_HOLD(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .detach(detach), .mapper_sel(mapper_sel),
        .rom_enabled(rom_enabled), .rom_size(rom_size), .load_err(load_err), .core_reset(core_reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int m_size[SLOTS];
    bit m_en[SLOTS];
    bit m_err;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < SLOTS; i++) begin
            m_size[i] = 0;
            m_en[i]   = 0;
        end
        m_err = 0;
    endtask

    task automatic check_model(input string tag);
        logic [SLOTS-1:0]    e_en;
        logic [SLOTS*SW-1:0] e_sz;
        for (int i = 0; i < SLOTS; i++) begin
            e_en[i]          = m_en[i];
            e_sz[i*SW +: SW] = SW'(m_size[i]);
        end
        #1;
        chk({tag, " rom_enabled"}, 128'(rom_enabled), 128'(e_en));
        chk({tag, " rom_size"}, 128'(rom_size), 128'(e_sz));
        chk({tag, " load_err"}, 128'(load_err), 128'(m_err));
    endtask

    task automatic start(input int s);
        bus.ioctl_index    = 8'(IB + s);
        bus.ioctl_download = 1'b1;
        tick(1);
        m_en[s]   = 0;
        m_size[s] = 0;
        m_err     = 0;
    endtask

    task automatic stop(input int s, input string tag);
        bus.ioctl_download = 1'b0;
        tick(2);
        m_en[s] = m_size[s] != 0;
        check_model(tag);
    endtask

    // Presents one byte; sdram_ready pulses rdly cycles after sdram_we.
    task automatic send_byte(input logic [26:0] off, input logic [7:0] d, input int rdly,
                             input bit dup, input bit cart, input int s, input string tag);
        int waits, wes, ready_at;
        logic [24:0] a;
        logic [7:0] q;
        bit acc;
        acc = cart && (off < 27'h100000);
        waits = 0; wes = 0; ready_at = -1; a = '0; q = '0;
        bus.ioctl_addr = off;
        bus.ioctl_dout = d;
        bus.ioctl_wr   = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (!bus.ioctl_wait) break;
            waits++;
            if (bus.sdram_we) begin
                wes++;
                a = bus.sdram_addr;
                q = bus.sdram_din;
                ready_at = c + rdly;
            end
            bus.sdram_ready = (c == ready_at);
            @(negedge clk);
            #1;
            bus.ioctl_wr = dup && (c == 1);
        end
        bus.sdram_ready = 1'b0;
        if (bus.ioctl_wr) begin
            @(negedge clk);
            #1;
            bus.ioctl_wr = 1'b0;
        end
        chk({tag, " wait_cycles"}, 128'(waits), 128'(acc ? rdly + 2 : 0));
        chk({tag, " we_count"}, 128'(wes), 128'(acc));
        if (acc) begin
            chk({tag, " sdram_addr"}, 128'(a), 128'(25'(BASE + s * 32'h100000 + int'(off))));
            chk({tag, " sdram_din"}, 128'(q), 128'(d));
            if (m_size[s] < int'(off) + 1) m_size[s] = int'(off) + 1;
        end
        if (cart && (!acc || dup)) m_err = 1;
    endtask

    task automatic count_rst(output int n);
        n = 0;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (!core_reset) break;
            n++;
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        int n;
        bus.ioctl_download = 0; bus.ioctl_index = 0; bus.ioctl_wr = 0;
        bus.ioctl_addr = 0; bus.ioctl_dout = 0; bus.sdram_ready = 0;
        detach = 0; mapper_sel = 16'h0030; reset_n = 0;
        model_clear();
        tick(3);
        #1;
        chk("reset ioctl_wait", 128'(bus.ioctl_wait), 128'(0));
        chk("reset sdram_we", 128'(bus.sdram_we), 128'(0));
        chk("reset core_reset", 128'(core_reset), 128'(0));
        check_model("reset");
        reset_n = 1;
        tick(1);

        // slot 0: four consecutive bytes, ready two cycles after each write
        start(0);
        for (int i = 0; i < 4; i++) send_byte(27'(i), 8'($urandom), 2, 0, 1, 0, "t1");
        stop(0, "t1 end");

        // slot 1: single byte, then an out-of-window offset in the same download
        start(1);
        send_byte(27'h10, 8'hA5, 1, 0, 1, 1, "t2");
        send_byte(27'h100000, 8'h5A, 1, 0, 1, 1, "t3 oow");
        check_model("t3");
        stop(1, "t2 end");

        // randomized downloads, including window-edge offsets and busy writes
        for (int it = 0; it < 8; it++) begin
            int s, nb;
            s  = int'($urandom_range(0, SLOTS - 1));
            nb = int'($urandom_range(1, 4));
            start(s);
            for (int b = 0; b < nb; b++) begin
                int pick;
                logic [26:0] off;
                bit dup;
                pick = int'($urandom_range(0, 5));
                off  = pick == 0 ? 27'(32'h100000 + $urandom_range(0, 1000)) :
                       pick == 1 ? 27'h0FFFFF : 27'($urandom_range(0, 32'h0FFFFF));
                dup  = (off < 27'h100000) && ($urandom_range(0, 3) == 0);
                send_byte(off, 8'($urandom), int'($urandom_range(1, 3)), dup, 1, s, "rand");
            end
            stop(s, "rand end");
        end

        // mapper change on slot 1 while idle
        count_rst(n);
        mapper_sel[7:4] = 4'd5;
        tick(1);
        count_rst(n);
        chk("t5 core_reset len", 128'(n), 128'(16));
        check_model("t5");

        // downloads to non-cart indices are ignored entirely
        bus.ioctl_index = 8'd0;
        bus.ioctl_download = 1'b1;
        tick(2);
        #1;
        chk("noncart core_reset", 128'(core_reset), 128'(0));
        send_byte(27'h0, 8'h11, 1, 0, 0, 0, "noncart");
        bus.ioctl_download = 1'b0;
        check_model("noncart");

        // detach in the same cycle the download ends
        start(2);
        send_byte(27'h20, 8'h33, 1, 0, 1, 2, "t4");
        bus.ioctl_download = 1'b0;
        detach = 1'b1;
        tick(1);
        detach = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            m_en[i]   = 0;
            m_size[i] = 0;
        end
        count_rst(n);
        chk("t4 core_reset len", 128'(n), 128'(16));
        check_model("t4");

        // reset during WAIT, then a clean reload of slot 0
        start(0);
        bus.ioctl_addr = 27'h5;
        bus.ioctl_dout = 8'h77;
        bus.ioctl_wr = 1'b1;
        tick(1);
        bus.ioctl_wr = 1'b0;
        tick(1);
        #1;
        chk("t6 wait before reset", 128'(bus.ioctl_wait), 128'(1));
        reset_n = 1'b0;
        bus.ioctl_download = 1'b0;
        tick(1);
        #1;
        chk("t6 ioctl_wait", 128'(bus.ioctl_wait), 128'(0));
        chk("t6 sdram_we", 128'(bus.sdram_we), 128'(0));
        chk("t6 core_reset", 128'(core_reset), 128'(0));
        model_clear();
        check_model("t6");
        tick(2);
        chk("t6 sdram_we held", 128'(bus.sdram_we), 128'(0));
        reset_n = 1'b1;
        tick(1);
        start(0);
        for (int i = 0; i < 4; i++) send_byte(27'(i), 8'($urandom), 2, 0, 1, 0, "t6 reload");
        stop(0, "t6 reload end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
